// File: rtl/flag_scan.sv
// Scans NUM_FLAGS source words for MATCH_VALUE and writes a 1 (or optionally 0)
// flag word to a result block, accumulating a match mask and a match count.
module flag_scan #(
  parameter int                    WORD_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 11,
  parameter int                    NUM_FLAGS   = 4,
  parameter int                    SRC_BASE    = 0,
  parameter int                    DST_BASE    = 16,
  parameter logic [WORD_WIDTH-1:0] MATCH_VALUE = WORD_WIDTH'(1),
  parameter int                    WRITE_ZERO  = 0
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic [NUM_FLAGS-1:0]  flag_mask,
  output logic [4:0]            match_count,
  output logic                  done
);

  localparam logic [3:0]            LAST_IDX = 4'(NUM_FLAGS - 1);
  localparam logic [ADDR_WIDTH-1:0] SRC_ADDR = ADDR_WIDTH'(SRC_BASE);
  localparam logic [ADDR_WIDTH-1:0] DST_ADDR = ADDR_WIDTH'(DST_BASE);
  localparam logic [NUM_FLAGS-1:0]  BIT0     = NUM_FLAGS'(1);

  typedef enum logic [2:0] {HOLD, ARMED, EVAL, WRITE, DONE} state_t;

  state_t                 state;
  logic [3:0]             idx;
  logic [3:0]             idx_next;
  logic [NUM_FLAGS-1:0]   idx_bit;
  logic                   match;

  assign idx_next = idx + 4'd1;
  assign idx_bit  = BIT0 << idx;
  // Full-width compare: partial matches on the low byte do not count.
  assign match    = (data_in == MATCH_VALUE);

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state       <= HOLD;
      idx         <= 4'd0;
      address     <= SRC_ADDR;
      wr_en       <= 1'b0;
      data_out    <= '0;
      flag_mask   <= '0;
      match_count <= 5'd0;
      done        <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        HOLD: begin
          if (en) begin
            flag_mask   <= '0;
            match_count <= 5'd0;
            done        <= 1'b0;
            idx         <= 4'd0;
            address     <= SRC_ADDR;
            state       <= ARMED;
          end
        end
        ARMED: begin
          if (start) begin
            address <= SRC_ADDR;
            idx     <= 4'd0;
            state   <= EVAL;
          end
        end
        EVAL: begin
          // data_in reflects the source address set on the previous edge.
          if (match) begin
            flag_mask   <= flag_mask | idx_bit;
            match_count <= match_count + 5'd1;
            address     <= DST_ADDR + ADDR_WIDTH'(idx);
            data_out    <= WORD_WIDTH'(1);
            wr_en       <= 1'b1;
            state       <= WRITE;
          end else if (WRITE_ZERO != 0) begin
            flag_mask <= flag_mask & ~idx_bit;
            address   <= DST_ADDR + ADDR_WIDTH'(idx);
            data_out  <= '0;
            wr_en     <= 1'b1;
            state     <= WRITE;
          end else if (idx != LAST_IDX) begin
            idx     <= idx_next;
            address <= SRC_ADDR + ADDR_WIDTH'(idx_next);
          end else begin
            state <= DONE;
          end
        end
        WRITE: begin
          if (idx != LAST_IDX) begin
            idx     <= idx_next;
            address <= SRC_ADDR + ADDR_WIDTH'(idx_next);
            state   <= EVAL;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= HOLD;
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_scan.sv
// Bench for flag_scan: three instances (defaults, WRITE_ZERO=1, MATCH_VALUE=A5A5)
// share control inputs, each reading its own combinational memory.
module tb_flag_scan;

  typedef struct packed {
    logic [10:0] a;
    logic [15:0] d;
  } wr_t;

  localparam int          WZ [3] = '{0, 1, 0};
  localparam logic [15:0] MV [3] = '{16'h0001, 16'h0001, 16'hA5A5};

  logic        clock;
  logic        nrst, en, start;
  logic [15:0] data_in     [3];
  logic [10:0] address     [3];
  logic        wr_en       [3];
  logic [15:0] data_out    [3];
  logic [3:0]  flag_mask   [3];
  logic [4:0]  match_count [3];
  logic        done        [3];

  logic [15:0] mem [3][32];

  int   checks = 0;
  int   errors = 0;
  bit   mon = 0;
  wr_t  wq [3][$];
  logic [3:0]  expm [3];
  int   expc [3];
  int   nw   [3];
  int   lat  [3];
  bit   got  [3];
  bit   post [3];
  logic [15:0] last_data [3];
  logic        prev_wr   [3];

  flag_scan #(.WRITE_ZERO(0)) u0 (
    .clock(clock), .nrst(nrst), .en(en), .start(start), .data_in(data_in[0]),
    .address(address[0]), .wr_en(wr_en[0]), .data_out(data_out[0]),
    .flag_mask(flag_mask[0]), .match_count(match_count[0]), .done(done[0]));

  flag_scan #(.WRITE_ZERO(1)) u1 (
    .clock(clock), .nrst(nrst), .en(en), .start(start), .data_in(data_in[1]),
    .address(address[1]), .wr_en(wr_en[1]), .data_out(data_out[1]),
    .flag_mask(flag_mask[1]), .match_count(match_count[1]), .done(done[1]));

  flag_scan #(.MATCH_VALUE(16'hA5A5)) u2 (
    .clock(clock), .nrst(nrst), .en(en), .start(start), .data_in(data_in[2]),
    .address(address[2]), .wr_en(wr_en[2]), .data_out(data_out[2]),
    .flag_mask(flag_mask[2]), .match_count(match_count[2]), .done(done[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    for (int k = 0; k < 3; k++) data_in[k] = mem[k][address[k][4:0]];
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [u%0d]: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_address", k, 32'(address[k]), 32'(0));
      chk("rst_wr_en", k, 32'(wr_en[k]), 32'(0));
      chk("rst_data_out", k, 32'(data_out[k]), 32'(0));
      chk("rst_flag_mask", k, 32'(flag_mask[k]), 32'(0));
      chk("rst_match_count", k, 32'(match_count[k]), 32'(0));
      chk("rst_done", k, 32'(done[k]), 32'(0));
    end
  endtask

  // Expected result of one scan straight from the flag rules.
  task automatic build_model();
    for (int k = 0; k < 3; k++) begin
      wq[k].delete();
      expm[k] = 4'b0;
      expc[k] = 0;
      nw[k]   = 0;
      for (int i = 0; i < 4; i++) begin
        bit  m;
        wr_t w;
        m = (mem[k][i] == MV[k]);
        if (m) begin
          expm[k][i] = 1'b1;
          expc[k]++;
        end
        if (m || WZ[k] != 0) begin
          w.a = 11'(16 + i);
          w.d = m ? 16'd1 : 16'd0;
          wq[k].push_back(w);
          nw[k]++;
        end
      end
    end
  endtask

  // Every cycle: each write pulse must be the next one the model expects,
  // pulses are isolated, and data_out holds between writes.
  always @(negedge clock) begin
    if (mon) begin
      for (int k = 0; k < 3; k++) begin
        wr_t w;
        if (wr_en[k]) begin
          chk("wr_gap", k, 32'(prev_wr[k]), 32'(0));
          if (wq[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write [u%0d]: addr %0d data %0h, none expected",
                     k, address[k], data_out[k]);
          end else begin
            w = wq[k].pop_front();
            chk("wr_addr", k, 32'(address[k]), 32'(w.a));
            chk("wr_data", k, 32'(data_out[k]), 32'(w.d));
            last_data[k] = w.d;
          end
        end else if (nrst) begin
          chk("data_hold", k, 32'(data_out[k]), 32'(last_data[k]));
        end
        prev_wr[k] = wr_en[k];
        if (!nrst) begin
          last_data[k] = '0;
          prev_wr[k]   = 1'b0;
        end
      end
    end
  end

  task automatic run_scan(input bit held);
    bit all;
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0; got[k] = 0; post[k] = 0;
    end
    if (!held) begin
      en = 1; tick(); en = 0;
    end else begin
      en = 1; start = 1; tick(); start = 0;
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
        chk("armed_done", k, 32'(done[k]), 32'(0));
        chk("armed_address", k, 32'(address[k]), 32'(0));
      end
    end
    start = 1; tick(); start = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      all = 1;
      for (int k = 0; k < 3; k++) begin
        if (held && got[k] && !post[k]) begin
          chk("done_cleared_by_en", k, 32'(done[k]), 32'(0));
          chk("mask_cleared_by_en", k, 32'(flag_mask[k]), 32'(0));
          post[k] = 1;
        end
        if (!got[k] && done[k]) begin
          got[k] = 1;
          lat[k] = n + 1;
          chk("latency", k, 32'(lat[k]), 32'(4 + nw[k] + 2));
          chk("flag_mask", k, 32'(flag_mask[k]), 32'(expm[k]));
          chk("match_count", k, 32'(match_count[k]), 32'(expc[k]));
          chk("writes_left", k, 32'(wq[k].size()), 32'(0));
        end
        if (!got[k] || (held && !post[k])) all = 0;
      end
      if (all) break;
    end
    for (int k = 0; k < 3; k++) begin
      if (!got[k] || (held && !post[k])) begin
        checks++;
        errors++;
        $display("FAIL timeout [u%0d]: done seen %0d, expected within 40 cycles", k, got[k]);
      end
    end
    if (!held) begin
      repeat (2) tick();
      for (int k = 0; k < 3; k++) begin
        chk("done_stable", k, 32'(done[k]), 32'(1));
        chk("mask_stable", k, 32'(flag_mask[k]), 32'(expm[k]));
      end
    end
    en = 0;
  endtask

  task automatic load(input int k, input logic [15:0] m0, input logic [15:0] m1,
                      input logic [15:0] m2, input logic [15:0] m3);
    mem[k][0] = m0; mem[k][1] = m1; mem[k][2] = m2; mem[k][3] = m3;
  endtask

  initial begin
    nrst = 0; en = 0; start = 0;
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 32; a++) mem[k][a] = 16'h0;
      last_data[k] = '0;
      prev_wr[k]   = 1'b0;
    end
    repeat (3) tick();
    chk_reset();
    nrst = 1; mon = 1;
    tick();

    // Mixed patterns; u2 sees 00A5 (no match) before A5A5 (match).
    load(0, 16'd1, 16'd0, 16'd1, 16'd0);
    load(1, 16'd0, 16'd0, 16'd0, 16'd1);
    load(2, 16'h00A5, 16'hA5A5, 16'h0000, 16'hA5A5);
    build_model();
    run_scan(0);
    chk("lit_mask_a", 0, 32'(flag_mask[0]), 32'(4'b0101));
    chk("lit_count_a", 0, 32'(match_count[0]), 32'(2));
    chk("lit_latency_a", 0, 32'(lat[0]), 32'(8));
    chk("lit_mask_a", 1, 32'(flag_mask[1]), 32'(4'b1000));
    chk("lit_count_a", 1, 32'(match_count[1]), 32'(1));
    chk("lit_latency_a", 1, 32'(lat[1]), 32'(10));
    chk("lit_mask_a", 2, 32'(flag_mask[2]), 32'(4'b1010));
    chk("lit_count_a", 2, 32'(match_count[2]), 32'(2));

    // All zeros on u0, all ones on u1, near-misses on u2.
    load(0, 16'd0, 16'd0, 16'd0, 16'd0);
    load(1, 16'd1, 16'd1, 16'd1, 16'd1);
    load(2, 16'hA5A5, 16'h00A5, 16'hA5A4, 16'hFFFF);
    build_model();
    run_scan(0);
    chk("lit_mask_b", 0, 32'(flag_mask[0]), 32'(0));
    chk("lit_latency_b", 0, 32'(lat[0]), 32'(6));
    chk("lit_count_b", 1, 32'(match_count[1]), 32'(4));
    chk("lit_mask_b", 2, 32'(flag_mask[2]), 32'(4'b0001));

    // start together with en in HOLD only arms; en stays high through DONE.
    load(0, 16'd1, 16'd1, 16'd0, 16'd1);
    build_model();
    run_scan(1);
    chk("lit_latency_c", 0, 32'(lat[0]), 32'(9));
    tick();

    // Reset while u0 is issuing the write for flag 1.
    load(0, 16'd0, 16'd1, 16'd1, 16'd0);
    build_model();
    en = 1; tick(); en = 0;
    start = 1; tick(); start = 0;
    tick(); tick();
    chk("pre_reset_wr_en", 0, 32'(wr_en[0]), 32'(1));
    chk("pre_reset_address", 0, 32'(address[0]), 32'(17));
    nrst = 0;
    tick(); #2;
    chk_reset();
    for (int k = 0; k < 3; k++) wq[k].delete();
    tick();
    nrst = 1;
    repeat (4) tick();
    for (int k = 0; k < 3; k++) chk("post_reset_idle", k, 32'(wr_en[k]), 32'(0));
    build_model();
    run_scan(0);
    chk("lit_mask_d", 0, 32'(flag_mask[0]), 32'(4'b0110));
    chk("lit_count_d", 0, 32'(match_count[0]), 32'(2));

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
